// File: rtl/seg7_pkg.sv
// Shared types, glyph constants and hex-to-segment helper for the 7-segment scan controller.
package seg7_pkg;

  typedef logic [3:0] bright_t;

  // Segment order {a,b,c,d,e,f,g,dp}, active high
  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;
  localparam logic [7:0] SEG_A     = 8'hEE;
  localparam logic [7:0] SEG_B     = 8'h3E;
  localparam logic [7:0] SEG_C     = 8'h9C;
  localparam logic [7:0] SEG_D     = 8'h7A;
  localparam logic [7:0] SEG_E     = 8'h9E;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble + decimal point to segment pattern.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg_c
);

  always_comb seg_c = hex_to_seg(nibble) | {7'd0, dp};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with PWM brightness, LZ suppression and frame latching.
// Optional blinking is enabled by defining SEG7_BLINK_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SUB_CYCLES   = 12500,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [3:0]              bright_in,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   seg_en,
  output logic [7:0]              seg_out0,
  output logic [7:0]              seg_out1,
  output logic                    frame_start
);

  localparam int unsigned SUB_W = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic [SUB_W-1:0] sub_cnt;
  logic [3:0]       phase;
  logic [IDX_W-1:0] idx;
  logic             sub_last, slot_last, frame_last;

  assign sub_last   = (sub_cnt == SUB_W'(SUB_CYCLES - 1));
  assign slot_last  = sub_last && (phase == 4'd15);
  assign frame_last = slot_last && (idx == IDX_W'(NUM_DIGITS - 1));

  // Scan timing: sub-slot cycles -> PWM phase -> digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_cnt <= '0;
      phase   <= '0;
      idx     <= '0;
    end else if (sub_last) begin
      sub_cnt <= '0;
      phase   <= phase + 4'd1;
      if (slot_last) idx <= frame_last ? '0 : idx + IDX_W'(1);
    end else begin
      sub_cnt <= sub_cnt + SUB_W'(1);
    end
  end

  // A digit is LZ-blanked when it and every digit above it show a bare zero
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  zero_above;
  always_comb begin
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above  = zero_above && (hex_in[4*i +: 4] == 4'd0) && !dp_in[i];
      lz_blank[i] = lz_en && zero_above && (i != 0);
    end
  end

  logic [4*NUM_DIGITS-1:0] sh_hex;
  logic [NUM_DIGITS-1:0]   sh_dp, sh_blank;
  bright_t                 sh_bright;

  // Shadow copy taken only at the frame boundary so a frame never tears
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_hex    <= '0;
      sh_dp     <= '0;
      sh_blank  <= '1;
      sh_bright <= 4'hF;
    end else if (frame_last) begin
      sh_hex    <= hex_in;
      sh_dp     <= dp_in;
      sh_blank  <= blank_in | lz_blank;
      sh_bright <= bright_in;
    end
  end

  logic [NUM_DIGITS-1:0] blink_blank;

`ifdef SEG7_BLINK_EN
  localparam int unsigned BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [NUM_DIGITS-1:0] sh_blink;
  logic [BF_W-1:0]       frame_cnt;
  logic                  blink_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_blink    <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_last) begin
      sh_blink <= blink_mask;
      if (frame_cnt == BF_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + BF_W'(1);
      end
    end
  end

  assign blink_blank = sh_blink & {NUM_DIGITS{blink_phase}};
`else
  localparam int unsigned unused_blink_frames = BLINK_FRAMES;
  logic unused_blink_mask;
  assign unused_blink_mask = ^blink_mask;
  assign blink_blank       = '0;
`endif

  logic [7:0] glyph_c;
  logic       lit;

  seg7_decoder u_dec (
    .nibble (sh_hex[{idx, 2'b00} +: 4]),
    .dp     (sh_dp[idx]),
    .seg_c  (glyph_c)
  );

  assign lit = !(sh_blank[idx] | blink_blank[idx]) && (phase <= sh_bright);

  // Pin register: one cycle behind the counter state it reflects
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_en      <= '0;
      seg_out0    <= SEG_BLANK;
      seg_out1    <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      seg_en      <= lit ? (NUM_DIGITS'(1) << idx) : '0;
      seg_out0    <= lit ? glyph_c : SEG_BLANK;
      seg_out1    <= lit ? glyph_c : SEG_BLANK;
      frame_start <= (idx == '0) && (phase == 4'd0) && (sub_cnt == '0);
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl against a frame-level reference model.
module tb_seg7_scan_ctrl;

  localparam int unsigned ND    = 4;
  localparam int unsigned SUB   = 2;
  localparam int unsigned BF    = 2;
  localparam int unsigned SLOT  = 16 * SUB;
  localparam int unsigned FRAME = SLOT * ND;

  localparam logic [7:0] GLYPH [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   hex_in;
  logic [ND-1:0] dp_in, blank_in, blink_mask;
  logic [3:0]    bright_in;
  logic          lz_en;
  logic [ND-1:0] seg_en;
  logic [7:0]    seg_out0, seg_out1;
  logic          frame_start;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .SUB_CYCLES   (SUB),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hex_in      (hex_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .bright_in   (bright_in),
    .lz_en       (lz_en),
    .blink_mask  (blink_mask),
    .seg_en      (seg_en),
    .seg_out0    (seg_out0),
    .seg_out1    (seg_out1),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: cycles since reset plus the picture latched for the current frame
  int unsigned   e;
  logic [15:0]   m_hex;
  logic [ND-1:0] m_dp, m_blank, m_blink;
  logic [3:0]    m_bright;
  logic [ND-1:0] x_en;
  logic [7:0]    x_seg;
  logic          x_fs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic latch();
    m_hex    = hex_in;
    m_dp     = dp_in;
    m_bright = bright_in;
    m_blink  = blink_mask;
    for (int i = 0; i < int'(ND); i++)
      m_blank[i] = blank_in[i] | (lz_en && (i != 0) &&
                   ((hex_in >> (4 * i)) == '0) && ((dp_in >> i) == '0));
  endtask

  task automatic tick();
    int unsigned s, di, ph;
    logic blk, lit;
    @(posedge clk);
    if (rst) begin
      x_en = '0; x_seg = '0; x_fs = 1'b0; e = 0;
      m_hex = '0; m_dp = '0; m_blank = '1; m_bright = 4'hF; m_blink = '0;
    end else begin
      s   = e % FRAME;
      di  = s / SLOT;
      ph  = (s % SLOT) / SUB;
      blk = m_blank[di];
`ifdef SEG7_BLINK_EN
      if (((e / FRAME) / BF) % 2 == 1) blk = blk | m_blink[di];
`endif
      lit   = !blk && (ph <= 32'(m_bright));
      x_en  = lit ? ND'(1 << di) : '0;
      x_seg = lit ? (GLYPH[m_hex[4*di +: 4]] | {7'd0, m_dp[di]}) : 8'd0;
      x_fs  = (s == 0);
      if (s == FRAME - 1) latch();
      e++;
    end
    #1;
    check("seg_en",      32'(seg_en),      32'(x_en));
    check("seg_out0",    32'(seg_out0),    32'(x_seg));
    check("seg_out1",    32'(seg_out1),    32'(x_seg));
    check("frame_start", 32'(frame_start), 32'(x_fs));
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; hex_in = 16'h1234; dp_in = '0; blank_in = '0;
    bright_in = 4'hF; lz_en = 1'b0; blink_mask = '0;
    repeat (3) tick();
    rst = 1'b0;
    run(3 * FRAME);

    bright_in = 4'd3;
    run(2 * FRAME);

    bright_in = 4'hF; lz_en = 1'b1; hex_in = 16'h0070;
    run(2 * FRAME);
    dp_in = 4'b1000;
    run(2 * FRAME);

    lz_en = 1'b0; dp_in = '0; hex_in = 16'hAAAA;
    run(FRAME + 40);
    hex_in = 16'h5555;
    run(2 * FRAME);

    // Reset in the middle of the idx=2 slot
    while ((e % FRAME) < 2 * SLOT + 5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    run(3 * FRAME);

    blink_mask = 4'b0001;
    run(6 * FRAME);

    for (int k = 0; k < 40; k++) begin
      hex_in     = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp_in      = ($urandom_range(0, 2) == 0) ? ND'($urandom) : '0;
      blank_in   = ($urandom_range(0, 3) == 0) ? ND'($urandom) : '0;
      bright_in  = 4'($urandom);
      lz_en      = 1'($urandom);
      blink_mask = ND'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end
      run($urandom_range(1, 300));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
